// File: rtl/master_bus_pkg.sv
// Purpose : shared types and constants for the master register bus arbiter.
// Latency : n/a (types only).
// Backpressure: n/a.
// Contents: FSM state enum, bus register map, STAT_REG bit positions, early-refusal helper.
package master_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STAT,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // Register map on the master bus
    localparam logic [1:0] ADDR_FIFO = 2'd0;
    localparam logic [1:0] ADDR_STAT = 2'd1;
    localparam logic [1:0] ADDR_MEM  = 2'd2;
    localparam logic [1:0] ADDR_NONE = 2'd3;

    // STAT_REG bit positions
    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_OVF   = 2;
    localparam int STAT_UNF   = 3;
    localparam int STAT_CLR   = 4;

    // Accesses refused before touching the bus: the unmapped address, and
    // writes to the read-only MEM register.
    function automatic logic refuse_early(input logic wr, input logic [1:0] addr);
        return (addr == ADDR_NONE) || (wr && (addr == ADDR_MEM));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose : round-robin pick of the first set request at or after i_ptr (wrapping).
// Latency : combinational.
// Backpressure: none; caller decides when the grant is taken.
// Ports   : i_req  request vector, i_ptr  search start index,
//           o_gnt  one-hot grant, o_idx  grant index, o_any  some request set.
module rr_arbiter
    import master_bus_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    logic [IW-1:0] w_j;
    logic          w_found;

    always_comb begin
        w_j     = '0;
        w_found = 1'b0;
        o_gnt   = '0;
        o_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = IW'((int'(i_ptr) + k) % NREQ);
            if (!w_found && i_req[w_j]) begin
                w_found    = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = w_j;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/master_bus_arbiter.sv
// Purpose : shares the master register bus between NREQ requesters, one transaction
//           at a time, round-robin, with a STAT pre-read guarding FIFO (addr 0) accesses.
// Latency : accept->rsp_valid 2 cycles, +1 with STAT pre-read, +1 for FIFO read wait;
//           refused-in-IDLE accesses respond after 1 cycle.
// Backpressure: req_ready only in IDLE, so a requester holds its request until granted.
// Ports   : clk, rst (sync, active high); req_valid/write/addr/wdata in, req_ready out;
//           rsp_valid/rsp_rdata/rsp_err out; m_enable/addr/write/read/wdata out, m_rdata in.
module master_bus_arbiter
    import master_bus_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int STAT_CHECK = 1,
    parameter int RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_write,
    input  logic [2*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_err,
    output logic              m_enable,
    output logic [1:0]        m_addr,
    output logic              m_write,
    output logic              m_read,
    output logic [7:0]        m_wdata,
    input  logic [7:0]        m_rdata
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t        r_state;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_gnt_idx;
    logic          r_write;
    logic [1:0]    r_addr;
    logic [7:0]    r_wdata;
    logic [7:0]    r_rdata;
    logic          r_err;

    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_idx;
    logic            w_any;
    logic            w_req_write;
    logic [1:0]      w_req_addr;
    logic [7:0]      w_req_wdata;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Select the granted requester's fields by shifting its slice down to bit 0.
    assign w_req_write = req_write[w_idx];
    assign w_req_addr  = 2'(req_addr >> {w_idx, 1'b0});
    assign w_req_wdata = 8'(req_wdata >> {w_idx, 3'b000});

    // Grant is only offered in IDLE; during reset nothing may be accepted
    // because the latch below would be discarded.
    assign req_ready = ((r_state == IDLE) && !rst) ? w_gnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_gnt_idx <= '0;
            r_write   <= 1'b0;
            r_addr    <= 2'd0;
            r_wdata   <= 8'h00;
            r_rdata   <= 8'h00;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt_idx <= w_idx;
                        r_write   <= w_req_write;
                        r_addr    <= w_req_addr;
                        r_wdata   <= w_req_wdata;
                        r_rdata   <= 8'h00;
                        r_err     <= 1'b0;
                        if (refuse_early(w_req_write, w_req_addr)) begin
                            r_err   <= 1'b1;
                            r_state <= RESP;
                        end else if ((w_req_addr == ADDR_FIFO) && (STAT_CHECK != 0)) begin
                            r_state <= STAT;
                        end else begin
                            r_state <= ISSUE;
                        end
                    end
                end
                STAT: begin
                    // Refuse a write into a full FIFO or a read from an empty one.
                    if ((r_write && m_rdata[STAT_FULL]) || (!r_write && m_rdata[STAT_EMPTY])) begin
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end else begin
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!r_write && (r_addr == ADDR_FIFO) && (RD_LAT != 0)) begin
                        r_state <= WAIT;
                    end else begin
                        if (!r_write) begin
                            r_rdata <= m_rdata;
                        end
                        r_state <= RESP;
                    end
                end
                WAIT: begin
                    r_rdata <= m_rdata;
                    r_state <= RESP;
                end
                RESP: begin
                    // Next search starts just past the requester served now.
                    r_ptr   <= (r_gnt_idx == IW'(NREQ - 1)) ? '0 : r_gnt_idx + 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Bus outputs depend only on state and latched request, never on req_*.
    always_comb begin
        m_enable = 1'b0;
        m_addr   = 2'd0;
        m_write  = 1'b0;
        m_read   = 1'b0;
        m_wdata  = 8'h00;
        case (r_state)
            STAT: begin
                m_enable = 1'b1;
                m_addr   = ADDR_STAT;
                m_read   = 1'b1;
            end
            ISSUE: begin
                m_enable = 1'b1;
                m_addr   = r_addr;
                m_write  = r_write;
                m_read   = !r_write;
                m_wdata  = r_write ? r_wdata : 8'h00;
            end
            default: ;
        endcase
    end

    assign rsp_valid = (r_state == RESP) ? ({{(NREQ-1){1'b0}}, 1'b1} << r_gnt_idx) : '0;
    assign rsp_rdata = (r_state == RESP) ? r_rdata : 8'h00;
    assign rsp_err   = (r_state == RESP) && r_err;

endmodule
